master_nios_pio_input_capture: RTL and testbench
================================================

Name: master_nios_pio_input_capture

Overview:
- Avalon-MM slave parallel input port: the read-side counterpart of the LED output PIO.
- Samples external inputs (slide switches/keys) through a 2-flop synchronizer, optionally debounces them, and detects edges.
- Latches detected edges in an edge-capture register and raises a level interrupt to the Nios master through a per-bit mask.

Parameters:
- WIDTH, 10, number of input bits (1..32).
- EDGE_TYPE, 0, edge kind captured: 0 rising, 1 falling, 2 any.
- DEBOUNCE_CYCLES, 16'd50000, stable-cycle count required when DEBOUNCE_EN is defined (1..65535).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  register word address.
- chipselect  in  1  slave select.
- read_n  in  1  active-low read strobe.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt, active high.

Behaviour:
- Single clock domain (clk). Reset is asynchronous and active-low (reset_n); every flop clears on reset_n low, regardless of clk.
- Reset values: sync stages, prev, irqmask, edgecapture, readdata all 0; irq 0.
- Synchronizer: s1 <= in_port; s2 <= s1. filt = s2, or the debounced value when DEBOUNCE_EN is defined. prev <= filt every cycle.
- Edge detect (combinational): rise = filt & ~prev; fall = ~filt & prev; det = rise, fall or (rise|fall) per EDGE_TYPE.
- Register map (word address):
  - 0 data, RO: {zero-extend, filt}. Writes are ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 irqmask, RW: bits WIDTH-1:0. Upper bits read 0.
  - 3 edgecapture, R/W1C: a written 1 clears that bit; a written 0 leaves it.
- Edgecapture update per bit, each clock: next = (cur & ~clr) | det, where clr = writedata bit on a write to address 3.
  - Simultaneous clear and new edge on the same bit: set wins, bit stays 1.
  - Repeated edges on an already set bit: the bit stays 1; edges are not counted.
- Write strobe: chipselect & ~write_n. Registers update on that clock edge.
- Read: readdata <= mux(address) when chipselect & ~read_n, otherwise readdata <= 0. Read latency is 1 cycle. A read has no side effects.
- irq = |(edgecapture & irqmask), combinational from registers.
  - Asserts in the cycle after the capturing edge.
  - Deasserts in the cycle after the clearing write, or after the mask write.
- Input-to-capture latency without debounce: a change sampled into s1 at edge k sets edgecapture at edge k+2; irq is high after edge k+2.
- No reset-time edge: prev and s-stages reset to 0, so an input held high through reset produces one rising edge after release. This is intended.
- Reset asserted mid-operation clears pending captures and the mask immediately; irq drops asynchronously with reset.

Optional Feature:
- Macro: MASTER_NIOS_PIO_DEBOUNCE_EN.
- Defined:
  - Each bit has a 16-bit counter and a filtered state.
  - While s2 differs from filt, the counter increments. When s2 equals filt, the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 with s2 still different, filt <= s2 and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never reach filt, data or edgecapture.
  - Added latency is DEBOUNCE_CYCLES cycles.
  - Counters and filt reset to 0.
- Undefined: filt = s2. No counters are synthesized.

Test Plan (WIDTH 10, DEBOUNCE_CYCLES 4 for debounce runs):
1. Reset, then in_port=10'h2A5 held; read addr 0 after 4 cycles -> readdata=32'h2A5, one cycle after the read strobe.
2. EDGE_TYPE 0, irqmask=10'h001; pulse in_port[0] 0->1 -> edgecapture=1 at k+2, irq=1; write addr3 with 1 -> edgecapture=0, irq=0 next cycle.
3. Edge on bit 3 in the same cycle as a W1C write of 10'h008 -> bit 3 remains 1. Writing 0 to addr3 leaves all bits unchanged.
4. irqmask=0, edge on bit 5 -> edgecapture=10'h020, irq stays 0; write irqmask=10'h020 -> irq=1 next cycle.
5. EDGE_TYPE 2: toggle bit 9 high then low, with a clear in between -> captured on both edges. Assert reset_n=0 mid-pending -> irq=0 and edgecapture=0 immediately.
6. MASTER_NIOS_PIO_DEBOUNCE_EN: a 3-cycle glitch on bit 1 -> no capture, data unchanged; a 6-cycle high on bit 1 -> capture after 4 stable cycles, data bit 1=1.

Source files
------------

// File: rtl/master_nios_pio_input_capture.sv
// Avalon-MM input PIO: synchronized inputs, W1C edge capture and a masked level irq.
// Defining MASTER_NIOS_PIO_DEBOUNCE_EN adds a per-bit debounce filter ahead of edge detection.
module master_nios_pio_input_capture #(
    parameter int          WIDTH           = 10,
    parameter int          EDGE_TYPE       = 0,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] s1, s2, filt, prev;
    logic [WIDTH-1:0] irqmask, edgecapture;
    logic [WIDTH-1:0] rise, fall, det, clr;
    logic [31:0]      read_mux;
    logic             wr_en, rd_en;
    logic             unused_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1   <= '0;
            s2   <= '0;
            prev <= '0;
        end else begin
            s1   <= in_port;
            s2   <= s1;
            prev <= filt;
        end
    end

`ifdef MASTER_NIOS_PIO_DEBOUNCE_EN
    logic [WIDTH-1:0][15:0] cnt;
    logic [WIDTH-1:0]       filt_q;

    // A bit only follows s2 after it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= '0;
            cnt    <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s2[i] == filt_q[i]) begin
                    cnt[i] <= 16'd0;
                end else if (cnt[i] == DEBOUNCE_CYCLES - 16'd1) begin
                    filt_q[i] <= s2[i];
                    cnt[i]    <= 16'd0;
                end else begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end

    assign filt = filt_q;
`else
    assign filt = s2;
`endif

    assign rise = filt & ~prev;
    assign fall = ~filt & prev;

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign det = rise;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign det = fall;
        end else begin : g_any
            assign det = rise | fall;
        end
    endgenerate

    assign wr_en        = chipselect & ~write_n;
    assign rd_en        = chipselect & ~read_n;
    assign clr          = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    assign unused_wdata = ^writedata;

    always_comb begin
        read_mux = 32'd0;
        case (address)
            2'd0:    read_mux[WIDTH-1:0] = filt;
            2'd2:    read_mux[WIDTH-1:0] = irqmask;
            2'd3:    read_mux[WIDTH-1:0] = edgecapture;
            default: read_mux = 32'd0;
        endcase
    end

    // New edges are OR-ed in after the clear so a same-cycle edge survives its W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask     <= '0;
            edgecapture <= '0;
            readdata    <= 32'd0;
        end else begin
            if (wr_en && address == 2'd2) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            edgecapture <= (edgecapture & ~clr) | det;
            readdata    <= rd_en ? read_mux : 32'd0;
        end
    end

    assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_master_nios_pio_input_capture.sv
// Bench for master_nios_pio_input_capture: three instances (rising, falling, any edge)
// share one bus and are compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_master_nios_pio_input_capture;
    localparam int          W       = 10;
    localparam logic [15:0] DB      = 16'd4;
    localparam int          NI      = 3;
    localparam int          OP_IDLE = 0;
    localparam int          OP_RD   = 1;
    localparam int          OP_WR   = 2;
    localparam int          OP_NOCS = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          read_n;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   rd_e0, rd_e1, rd_e2;
    logic          irq_e0, irq_e1, irq_e2;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    master_nios_pio_input_capture #(.WIDTH(W), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(DB)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_e0), .irq(irq_e0));
    master_nios_pio_input_capture #(.WIDTH(W), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(DB)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_e1), .irq(irq_e1));
    master_nios_pio_input_capture #(.WIDTH(W), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(DB)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_e2), .irq(irq_e2));

    // Reference model: the input as seen after the synchronizer, the filtered level,
    // its previous value, and per-instance mask / capture / read-data registers.
    logic [W-1:0] m_samp [$];
    logic [W-1:0] m_s2h  [$];
    logic [W-1:0] m_filt, m_prev;
    logic [W-1:0] m_mask [NI];
    logic [W-1:0] m_cap  [NI];
    logic [31:0]  m_rd   [NI];

    typedef struct {
        logic [W-1:0] inp;
        int           op;
        logic [1:0]   addr;
        logic [31:0]  wdata;
        logic [31:0]  exp_rd;
        logic         exp_irq;
    } vec_t;
    vec_t vecs [$];

    function automatic logic [31:0] get_rd(int e);
        case (e)
            0:       return rd_e0;
            1:       return rd_e1;
            default: return rd_e2;
        endcase
    endfunction

    function automatic logic get_irq(int e);
        case (e)
            0:       return irq_e0;
            1:       return irq_e1;
            default: return irq_e2;
        endcase
    endfunction

    task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(logic [W-1:0] inp, int op, logic [1:0] addr, logic [31:0] wdata);
        in_port   = inp;
        address   = addr;
        writedata = wdata;
        case (op)
            OP_RD:   begin chipselect = 1'b1; read_n = 1'b0; write_n = 1'b1; end
            OP_WR:   begin chipselect = 1'b1; read_n = 1'b1; write_n = 1'b0; end
            OP_NOCS: begin chipselect = 1'b0; read_n = 1'b0; write_n = 1'b0; end
            default: begin chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1; end
        endcase
    endtask

    task automatic model_reset();
        m_samp.delete();
        m_s2h.delete();
        repeat (2) m_samp.push_back('0);
        for (int j = 0; j < int'(DB); j++) m_s2h.push_back('0);
        m_filt = '0;
        m_prev = '0;
        for (int e = 0; e < NI; e++) begin
            m_mask[e] = '0;
            m_cap[e]  = '0;
            m_rd[e]   = 32'd0;
        end
    endtask

    // Advances the model by one clock using the inputs currently on the bus.
    task automatic model_step();
        logic [W-1:0] det, clr, s1v, s2v, nfilt;
        bit wr, rd, all_diff;
        wr  = chipselect && !write_n;
        rd  = chipselect && !read_n;
        s1v = m_samp[0];
        s2v = m_samp[1];
        clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
        for (int e = 0; e < NI; e++) begin
            case (e)
                0:       det = m_filt & ~m_prev;
                1:       det = ~m_filt & m_prev;
                default: det = m_filt ^ m_prev;
            endcase
            if (!rd)                  m_rd[e] = 32'd0;
            else if (address == 2'd0) m_rd[e] = 32'(m_filt);
            else if (address == 2'd2) m_rd[e] = 32'(m_mask[e]);
            else if (address == 2'd3) m_rd[e] = 32'(m_cap[e]);
            else                      m_rd[e] = 32'd0;
            m_cap[e] = (m_cap[e] & ~clr) | det;
            if (wr && address == 2'd2) m_mask[e] = writedata[W-1:0];
        end
        m_prev = m_filt;
`ifdef MASTER_NIOS_PIO_DEBOUNCE_EN
        m_s2h.push_front(s2v);
        void'(m_s2h.pop_back());
        nfilt = m_filt;
        for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            foreach (m_s2h[j]) if (m_s2h[j][b] == m_filt[b]) all_diff = 1'b0;
            if (all_diff) nfilt[b] = ~m_filt[b];
        end
        m_filt = nfilt;
`else
        nfilt    = s2v;
        all_diff = 1'b0;
        m_filt   = s1v;
`endif
        m_samp.push_front(in_port);
        void'(m_samp.pop_back());
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        for (int e = 0; e < NI; e++) begin
            check_output($sformatf("model_rd_e%0d", e), get_rd(e), m_rd[e]);
            check_output($sformatf("model_irq_e%0d", e), 32'(get_irq(e)), 32'(|(m_cap[e] & m_mask[e])));
        end
    endtask

    task automatic bus(int op, logic [1:0] addr, logic [31:0] wdata);
        apply_stimulus(in_port, op, addr, wdata);
        tick();
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) bus(OP_IDLE, 2'd0, 32'd0);
    endtask

    task automatic async_reset();
        #2;
        reset_n = 1'b0;
        #1;
        for (int e = 0; e < NI; e++) begin
            check_output($sformatf("async_rst_irq_e%0d", e), 32'(get_irq(e)), 32'd0);
            check_output($sformatf("async_rst_rd_e%0d", e), get_rd(e), 32'd0);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic void add_vec(logic [W-1:0] inp, int op, logic [1:0] addr,
                                    logic [31:0] wdata, logic [31:0] exp_rd, logic exp_irq);
        vec_t v;
        v.inp = inp; v.op = op; v.addr = addr; v.wdata = wdata;
        v.exp_rd = exp_rd; v.exp_irq = exp_irq;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [W-1:0] nin;
        reset_n = 1'b0;
        apply_stimulus('0, OP_IDLE, 2'd0, 32'd0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int e = 0; e < NI; e++) begin
            check_output($sformatf("reset_rd_e%0d", e), get_rd(e), 32'd0);
            check_output($sformatf("reset_irq_e%0d", e), 32'(get_irq(e)), 32'd0);
        end
        reset_n = 1'b1;

`ifndef MASTER_NIOS_PIO_DEBOUNCE_EN
        // Hand-derived expectations for the rising-edge instance, one record per clock.
        add_vec(10'h2A5, OP_IDLE, 2'd0, 32'h0,   32'h0,   1'b0);
        add_vec(10'h2A5, OP_IDLE, 2'd0, 32'h0,   32'h0,   1'b0);
        add_vec(10'h2A5, OP_IDLE, 2'd0, 32'h0,   32'h0,   1'b0);
        add_vec(10'h2A5, OP_RD,   2'd0, 32'h0,   32'h2A5, 1'b0);
        add_vec(10'h2A5, OP_RD,   2'd3, 32'h0,   32'h2A5, 1'b0);
        add_vec(10'h2A5, OP_WR,   2'd3, 32'h3FF, 32'h0,   1'b0);
        add_vec(10'h2A5, OP_RD,   2'd3, 32'h0,   32'h0,   1'b0);
        add_vec(10'h2A5, OP_WR,   2'd2, 32'h001, 32'h0,   1'b0);
        add_vec(10'h2A4, OP_IDLE, 2'd0, 32'h0,   32'h0,   1'b0);
        add_vec(10'h2A4, OP_IDLE, 2'd0, 32'h0,   32'h0,   1'b0);
        add_vec(10'h2A4, OP_IDLE, 2'd0, 32'h0,   32'h0,   1'b0);
        add_vec(10'h2A5, OP_IDLE, 2'd0, 32'h0,   32'h0,   1'b0);
        add_vec(10'h2A5, OP_IDLE, 2'd0, 32'h0,   32'h0,   1'b0);
        add_vec(10'h2A5, OP_IDLE, 2'd0, 32'h0,   32'h0,   1'b1);
        add_vec(10'h2A5, OP_RD,   2'd3, 32'h0,   32'h001, 1'b1);
        add_vec(10'h2A5, OP_WR,   2'd3, 32'h001, 32'h0,   1'b0);
        add_vec(10'h2AD, OP_IDLE, 2'd0, 32'h0,   32'h0,   1'b0);
        add_vec(10'h2AD, OP_IDLE, 2'd0, 32'h0,   32'h0,   1'b0);
        add_vec(10'h2AD, OP_WR,   2'd3, 32'h008, 32'h0,   1'b0);
        add_vec(10'h2AD, OP_RD,   2'd3, 32'h0,   32'h008, 1'b0);
        add_vec(10'h2AD, OP_WR,   2'd3, 32'h000, 32'h0,   1'b0);
        add_vec(10'h2AD, OP_RD,   2'd3, 32'h0,   32'h008, 1'b0);
        add_vec(10'h28D, OP_WR,   2'd2, 32'h000, 32'h0,   1'b0);
        add_vec(10'h28D, OP_WR,   2'd3, 32'h3FF, 32'h0,   1'b0);
        add_vec(10'h2AD, OP_IDLE, 2'd0, 32'h0,   32'h0,   1'b0);
        add_vec(10'h2AD, OP_IDLE, 2'd0, 32'h0,   32'h0,   1'b0);
        add_vec(10'h2AD, OP_IDLE, 2'd0, 32'h0,   32'h0,   1'b0);
        add_vec(10'h2AD, OP_RD,   2'd3, 32'h0,   32'h020, 1'b0);
        add_vec(10'h2AD, OP_WR,   2'd2, 32'h020, 32'h0,   1'b1);
        add_vec(10'h2AD, OP_RD,   2'd2, 32'h0,   32'h020, 1'b1);
        add_vec(10'h2AD, OP_RD,   2'd1, 32'h0,   32'h0,   1'b1);
        add_vec(10'h2AD, OP_WR,   2'd0, 32'h3FF, 32'h0,   1'b1);
        add_vec(10'h2AD, OP_RD,   2'd0, 32'h0,   32'h2AD, 1'b1);
        add_vec(10'h2AD, OP_WR,   2'd3, 32'h020, 32'h0,   1'b0);
        add_vec(10'h2AD, OP_NOCS, 2'd2, 32'h3FF, 32'h0,   1'b0);
        add_vec(10'h2AD, OP_RD,   2'd2, 32'h0,   32'h020, 1'b0);
        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].inp, vecs[i].op, vecs[i].addr, vecs[i].wdata);
            tick();
            check_output($sformatf("vec%0d_rd", i), rd_e0, vecs[i].exp_rd);
            check_output($sformatf("vec%0d_irq", i), 32'(irq_e0), 32'(vecs[i].exp_irq));
        end
`endif

        // Falling then rising edge on bit 9 with a clear in between, then reset while pending.
        apply_stimulus(10'h2AD, OP_IDLE, 2'd0, 32'd0);
        idle(12);
        bus(OP_WR, 2'd3, 32'hFFFF_FFFF);
        bus(OP_WR, 2'd2, 32'h0000_0200);
        apply_stimulus(10'h0AD, OP_IDLE, 2'd0, 32'd0);
        idle(10);
        check_output("fall_irq_any", 32'(irq_e2), 32'd1);
        check_output("fall_irq_fall", 32'(irq_e1), 32'd1);
        check_output("fall_irq_rise", 32'(irq_e0), 32'd0);
        bus(OP_RD, 2'd3, 32'd0);
        check_output("fall_cap_any", rd_e2, 32'h200);
        bus(OP_WR, 2'd3, 32'h200);
        check_output("clr_irq_any", 32'(irq_e2), 32'd0);
        apply_stimulus(10'h2AD, OP_IDLE, 2'd0, 32'd0);
        idle(10);
        check_output("rise_irq_any", 32'(irq_e2), 32'd1);
        check_output("rise_irq_rise", 32'(irq_e0), 32'd1);
        check_output("rise_irq_fall", 32'(irq_e1), 32'd0);
        async_reset();
        bus(OP_RD, 2'd3, 32'd0);
        check_output("post_rst_cap_any", rd_e2, 32'd0);
        idle(10);

`ifdef MASTER_NIOS_PIO_DEBOUNCE_EN
        // Short glitch must be filtered; a long pulse must pass after DB stable cycles.
        bus(OP_WR, 2'd3, 32'hFFFF_FFFF);
        apply_stimulus(10'h2AF, OP_IDLE, 2'd0, 32'd0);
        idle(3);
        apply_stimulus(10'h2AD, OP_IDLE, 2'd0, 32'd0);
        idle(8);
        bus(OP_RD, 2'd0, 32'd0);
        check_output("glitch_data_b1", rd_e0 & 32'h2, 32'd0);
        bus(OP_RD, 2'd3, 32'd0);
        check_output("glitch_cap_b1", rd_e2 & 32'h2, 32'd0);
        apply_stimulus(10'h2AF, OP_IDLE, 2'd0, 32'd0);
        idle(6);
        bus(OP_RD, 2'd0, 32'd0);
        check_output("pulse_data_b1", rd_e0 & 32'h2, 32'h2);
        bus(OP_RD, 2'd3, 32'd0);
        check_output("pulse_cap_b1", rd_e0 & 32'h2, 32'h2);
`endif

        // Randomized traffic and input activity, with one reset in the middle.
        for (int i = 0; i < 400; i++) begin
            nin = in_port;
            if ($urandom_range(0, 2) == 0) nin[$urandom_range(0, W - 1)] ^= 1'b1;
            apply_stimulus(nin, int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom);
            tick();
            if (i == 200) async_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
